// File: rtl/mux8_arb_pkg.sv
// rtl/mux8_arb_pkg.sv - shared state type, sizes and round-robin pick function
package mux8_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // Returns {found, index}: first set bit searching last+1, last+2, ... mod NUM_REQ.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [SEL_W-1:0]   last);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [SEL_W-1:0]     start;
    logic [SEL_W:0]       res;
    start = last + SEL_W'(1);
    dbl   = {req, req} >> start;
    rot   = dbl[NUM_REQ-1:0];
    res   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) res = {1'b1, SEL_W'(i) + start};
    end
    return res;
  endfunction

endpackage

// File: rtl/mux8_rr_pick.sv
// rtl/mux8_rr_pick.sv - combinational rotate / priority-encode / unrotate winner select
module mux8_rr_pick
  import mux8_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  assign {found, idx} = rr_pick(req, last);

endmodule

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin owner/select sequencer for an 8:1 mux (option: MUX8_ARB_MASK_EN)
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
`ifdef MUX8_ARB_MASK_EN
  input  logic [NUM_REQ-1:0] req_mask,
`endif
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [SEL_W-1:0]   sel,
  input  logic               mux_f,
  output logic               dout,
  output logic               dout_valid,
  output logic [SEL_W-1:0]   dout_src
);

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

  arb_state_e         state, state_n;
  logic [NUM_REQ-1:0] eff_req;
  logic [NUM_REQ-1:0] gnt_n;
  logic               gnt_valid_n;
  logic [SEL_W-1:0]   sel_n;
  logic [SEL_W-1:0]   last, last_n;
  logic [CNT_W-1:0]   hold_cnt, hold_n;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               release_owner;

`ifdef MUX8_ARB_MASK_EN
  assign eff_req = req & ~req_mask;
`else
  assign eff_req = req;
`endif

  mux8_rr_pick u_pick (
    .req   (eff_req),
    .last  (last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // sel doubles as the owner index while in GRANT
  assign release_owner = !eff_req[sel] || ((MAX_HOLD != 0) && (hold_cnt == HOLD_LIMIT));

  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    gnt_valid_n = gnt_valid;
    sel_n       = sel;
    last_n      = last;
    hold_n      = hold_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_n     = GRANT;
          gnt_n       = NUM_REQ'(1) << pick_idx;
          gnt_valid_n = 1'b1;
          sel_n       = pick_idx;
          hold_n      = CNT_W'(1);
        end
      end
      GRANT: begin
        if (release_owner) begin
          state_n     = GAP;
          gnt_n       = '0;
          gnt_valid_n = 1'b0;
          last_n      = sel;
          hold_n      = '0;
        end else if (hold_cnt != '1) begin
          hold_n = hold_cnt + CNT_W'(1);
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      sel       <= '0;
      last      <= SEL_W'(NUM_REQ - 1);
      hold_cnt  <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      gnt_valid <= gnt_valid_n;
      sel       <= sel_n;
      last      <= last_n;
      hold_cnt  <= hold_n;
    end
  end

  // Mux output comes back one cycle later, tagged with the select that produced it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      dout_src   <= '0;
    end else begin
      dout       <= mux_f;
      dout_valid <= gnt_valid;
      dout_src   <= sel;
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - directed self-checking bench for mux8_rr_arbiter
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] d = '0;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] sel;
  logic       mux_f;
  logic       dout;
  logic       dout_valid;
  logic [2:0] dout_src;
`ifdef MUX8_ARB_MASK_EN
  logic [7:0] req_mask = '0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mux_f = d[sel];

  mux8_rr_arbiter #(.MAX_HOLD(4), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
`ifdef MUX8_ARB_MASK_EN
    .req_mask   (req_mask),
`endif
    .gnt        (gnt),
    .gnt_valid  (gnt_valid),
    .sel        (sel),
    .mux_f      (mux_f),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_src   (dout_src)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    req   = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick();
    tick();
    check("rst_gnt", gnt, 8'h00);
    check("rst_gnt_valid", 8'(gnt_valid), 8'h0);
    check("rst_sel", 8'(sel), 8'h0);
    check("rst_dout", 8'(dout), 8'h0);
    check("rst_dout_valid", 8'(dout_valid), 8'h0);
    check("rst_dout_src", 8'(dout_src), 8'h0);

    // single requester 0, dout follows D0
    rst_n = 1'b1;
    req   = 8'h01;
    d     = 8'h01;
    tick();
    check("r0_gnt", gnt, 8'h01);
    check("r0_sel", 8'(sel), 8'h0);
    check("r0_gnt_valid", 8'(gnt_valid), 8'h1);
    check("r0_dout_valid_lag", 8'(dout_valid), 8'h0);
    tick();
    check("r0_dout_valid", 8'(dout_valid), 8'h1);
    check("r0_dout_hi", 8'(dout), 8'h1);
    check("r0_dout_src", 8'(dout_src), 8'h0);
    d = 8'h00;
    tick();
    check("r0_dout_lo", 8'(dout), 8'h0);
    check("r0_gnt_held", gnt, 8'h01);
    req = 8'h00;
    tick();
    check("r0_release_gnt", gnt, 8'h00);
    check("r0_release_valid", 8'(gnt_valid), 8'h0);
    check("r0_release_sel", 8'(sel), 8'h0);
    tick();

    // all requesting, hold limit 4: 4 grant cycles then 2 idle cycles per owner
    do_reset();
    req = 8'hFF;
    for (int o = 0; o < 9; o++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        check($sformatf("rr_gnt_o%0d_c%0d", o % 8, k), gnt, 8'(1 << (o % 8)));
        check($sformatf("rr_sel_o%0d_c%0d", o % 8, k), 8'(sel), 8'(o % 8));
      end
      tick();
      check($sformatf("rr_gap_gnt_o%0d", o % 8), gnt, 8'h00);
      check($sformatf("rr_gap_sel_o%0d", o % 8), 8'(sel), 8'(o % 8));
      tick();
      check($sformatf("rr_arb_gnt_o%0d", o % 8), gnt, 8'h00);
    end
    req = 8'h00;
    tick();
    check("idle_no_req", gnt, 8'h00);

    // owner 2 drops after 3 cycles, requester 5 waiting
    req = 8'h24;
    d   = 8'h20;
    tick();
    check("drop_gnt2", gnt, 8'h04);
    check("drop_sel2", 8'(sel), 8'h2);
    tick();
    tick();
    check("drop_gnt2_c3", gnt, 8'h04);
    req = 8'h20;
    tick();
    check("drop_gap_gnt", gnt, 8'h00);
    check("drop_gap_sel", 8'(sel), 8'h2);
    tick();
    check("drop_arb_gnt", gnt, 8'h00);
    tick();
    check("drop_gnt5", gnt, 8'h20);
    check("drop_sel5", 8'(sel), 8'h5);
    req = 8'h00;
    tick();
    check("d5_gnt_off", gnt, 8'h00);
    check("d5_dout_valid", 8'(dout_valid), 8'h1);
    check("d5_dout_src", 8'(dout_src), 8'h5);
    check("d5_dout", 8'(dout), 8'h1);
    tick();

    // make last=6, then 7 and 0 both request: 7 wins, preempted after 4, then 0
    req = 8'h40;
    tick();
    check("l6_gnt", gnt, 8'h40);
    req = 8'h81;
    tick();
    check("l6_gap", gnt, 8'h00);
    tick();
    check("l6_arb", gnt, 8'h00);
    tick();
    check("wrap_gnt7", gnt, 8'h80);
    check("wrap_sel7", 8'(sel), 8'h7);
    repeat (3) tick();
    check("wrap_gnt7_c4", gnt, 8'h80);
    tick();
    check("preempt_gap", gnt, 8'h00);
    tick();
    check("preempt_arb", gnt, 8'h00);
    tick();
    check("wrap_gnt0", gnt, 8'h01);
    check("wrap_sel0", 8'(sel), 8'h0);
    req = 8'h00;
    tick();
    tick();

    // asynchronous reset in the middle of owner 3's grant
    req = 8'h08;
    tick();
    check("ar_gnt3", gnt, 8'h08);
    check("ar_sel3", 8'(sel), 8'h3);
    #2 rst_n = 1'b0;
    #1;
    check("ar_async_gnt", gnt, 8'h00);
    check("ar_async_sel", 8'(sel), 8'h0);
    check("ar_async_valid", 8'(gnt_valid), 8'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_regrant_gnt", gnt, 8'h08);
    check("ar_regrant_sel", 8'(sel), 8'h3);
    check("ar_dout_valid", 8'(dout_valid), 8'h0);
    req = 8'h00;

`ifdef MUX8_ARB_MASK_EN
    do_reset();
    req      = 8'h0C;
    req_mask = 8'h04;
    tick();
    check("mask_gnt3", gnt, 8'h08);
    req_mask = 8'h08;
    tick();
    check("mask_release", gnt, 8'h00);
    req      = 8'h00;
    req_mask = 8'h00;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
